// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master: FSM states, port codes and bus widths.
package apb_pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int NUM_PORTS = 6;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam logic [2:0] PORT1 = 3'b010;
  localparam logic [2:0] PORT2 = 3'b011;
  localparam logic [2:0] PORT3 = 3'b100;
  localparam logic [2:0] PORT4 = 3'b101;
  localparam logic [2:0] PORT5 = 3'b110;
  localparam logic [2:0] PORT6 = 3'b111;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle: the master drives select/control/address/data, the slave side returns muxed read data and status.
interface apb_if;
  import apb_pkg::*;

  logic [NUM_PORTS-1:0] psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDR_W-1:0]    paddr;
  logic [DATA_W-1:0]    pwdata;
  logic [DATA_W-1:0]    prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_port_decode.sv
// Combinational decode of a 3-bit port code into a one-hot peripheral select plus a valid flag.
module apb_port_decode
  import apb_pkg::*;
(
  input  logic [2:0]           code,
  output logic [NUM_PORTS-1:0] onehot,
  output logic                 valid
);

  // NOTE: defaulting every output before the case keeps this purely combinational (no latch).
  always_comb begin
    onehot = '0;
    valid  = 1'b1;
    case (code)
      PORT1:   onehot = 6'b000001;
      PORT2:   onehot = 6'b000010;
      PORT3:   onehot = 6'b000100;
      PORT4:   onehot = 6'b001000;
      PORT5:   onehot = 6'b010000;
      PORT6:   onehot = 6'b100000;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: request/response handshake in, APB SETUP/ACCESS sequencing out, with pready timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_port,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  apb_if.master             apb
);

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] dec_onehot;
  logic                 dec_valid;

  apb_port_decode u_decode (
    .code   (req_port),
    .onehot (dec_onehot),
    .valid  (dec_valid)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_valid) begin
            state_d  = SETUP;
            psel_d   = dec_onehot;
            pwrite_d = req_write;
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
            cnt_d    = '0;
          end else begin
            // Undecodable port: answer with an error without touching the bus.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (apb.pready) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = apb.pslverr;
          rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d     = RESP;
            psel_d      = '0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a vector table of single transfers plus hand-built timeout, backpressure and reset sequences.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_port = 3'b000;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  apb_if bus ();

  apb_master #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_port  (req_port),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  port;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;
    logic [5:0]  exp_psel;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge; everything is driven and sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [2:0] port, input logic [11:0] addr,
                       input logic [31:0] wdata);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_port  = port;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_port  = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_after_ack", 32'(rsp_valid), 32'd0);
    check("req_ready_after_ack", 32'(req_ready), 32'd1);
    check("paddr_idle", 32'(bus.paddr), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.wr, v.port, v.addr, v.wdata);
    if (v.exp_psel != 6'b0) begin
      check("setup_psel", 32'(bus.psel), 32'(v.exp_psel));
      check("setup_penable", 32'(bus.penable), 32'd0);
      check("setup_paddr", 32'(bus.paddr), 32'(v.addr));
      check("setup_pwrite", 32'(bus.pwrite), 32'(v.wr));
      check("setup_pwdata", bus.pwdata, v.wdata);
      // Status presented during SETUP must be ignored.
      bus.pready  = 1'b1;
      bus.pslverr = 1'b1;
      tick();
      for (int w = 0; w <= v.waits; w++) begin
        check("access_psel", 32'(bus.psel), 32'(v.exp_psel));
        check("access_penable", 32'(bus.penable), 32'd1);
        check("access_paddr", 32'(bus.paddr), 32'(v.addr));
        check("access_rsp_valid", 32'(rsp_valid), 32'd0);
        if (w == v.waits) begin
          bus.pready  = 1'b1;
          bus.pslverr = v.slverr;
          bus.prdata  = v.prdata;
        end else begin
          bus.pready  = 1'b0;
          bus.pslverr = 1'b1;
          bus.prdata  = 32'hBAD0_0000 | 32'(w);
        end
        tick();
      end
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'hCAFE_F00D;
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_psel", 32'(bus.psel), 32'd0);
    check("rsp_penable", 32'(bus.penable), 32'd0);
    check("rsp_req_ready", 32'(req_ready), 32'd0);
    finish_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.prdata  = 32'hCAFE_F00D;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;

    //               wr    port    addr     wdata         prdata        slv  w  psel       err   rdata
    vecs[0] = '{1'b1, 3'b010, 12'h00C, 32'hDEADBEEF, 32'h11111111, 1'b0, 0, 6'b000001, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 3'b111, 12'hFFF, 32'h0,        32'h12345678, 1'b0, 3, 6'b100000, 1'b0, 32'h12345678};
    vecs[2] = '{1'b1, 3'b001, 12'h055, 32'h0BAD0BAD, 32'h22222222, 1'b0, 0, 6'b000000, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 3'b000, 12'h066, 32'h0,        32'h33333333, 1'b0, 0, 6'b000000, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 3'b100, 12'h123, 32'h0,        32'hA5A5A5A5, 1'b1, 1, 6'b000100, 1'b1, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 3'b011, 12'h456, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 2, 6'b000010, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 3'b101, 12'h000, 32'h0,        32'h0BADF00D, 1'b0, 0, 6'b001000, 1'b0, 32'h0BADF00D};
    vecs[7] = '{1'b1, 3'b110, 12'hABC, 32'h76543210, 32'h44444444, 1'b1, 0, 6'b010000, 1'b1, 32'h0};

    // Reset state.
    rst = 1'b0;
    tick();
    tick();
    check("rst_psel", 32'(bus.psel), 32'd0);
    check("rst_penable", 32'(bus.penable), 32'd0);
    check("rst_pwrite", 32'(bus.pwrite), 32'd0);
    check("rst_paddr", 32'(bus.paddr), 32'd0);
    check("rst_pwdata", bus.pwdata, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Timeout: pready never rises, penable must stay high exactly TO cycles.
    issue(1'b0, 3'b010, 12'h010, 32'h0);
    check("to_setup_psel", 32'(bus.psel), 32'd1);
    check("to_setup_penable", 32'(bus.penable), 32'd0);
    bus.prdata = 32'hDEAD_0001;
    tick();
    for (int c = 0; c < TO; c++) begin
      check("to_penable_high", 32'(bus.penable), 32'd1);
      check("to_rsp_valid_low", 32'(rsp_valid), 32'd0);
      tick();
    end
    check("to_psel", 32'(bus.psel), 32'd0);
    check("to_penable", 32'(bus.penable), 32'd0);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    finish_rsp();

    // Slave error on a read, then response held under backpressure.
    issue(1'b0, 3'b100, 12'h200, 32'h0);
    tick();
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'h55AA55AA;
    tick();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = 32'h0;
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_err", 32'(rsp_err), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h55AA55AA);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    finish_rsp();

    // Reset asserted in the middle of ACCESS aborts with no response.
    issue(1'b1, 3'b111, 12'h321, 32'hFEEDFACE);
    tick();
    check("mid_penable", 32'(bus.penable), 32'd1);
    rst = 1'b0;
    tick();
    check("mid_rst_psel", 32'(bus.psel), 32'd0);
    check("mid_rst_penable", 32'(bus.penable), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    bus.pready = 1'b1;
    tick();
    check("mid_rel_req_ready", 32'(req_ready), 32'd1);
    check("mid_rel_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("mid_rel_psel", 32'(bus.psel), 32'd0);
    check("mid_rel_rsp_valid2", 32'(rsp_valid), 32'd0);
    bus.pready = 1'b0;

    // A clean transfer after the abort.
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
